// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// Each bit lasts CLKS_PER_BIT clocks so tx can loop straight into the 16x receiver.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] datain,
  input  logic       tx_en,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic       PAR_EN    = (PARITY_EN != 0);
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);

  state_t     state_reg,  state_next;
  logic [7:0] baud_reg,   baud_next;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic [7:0] shift_reg,  shift_next;
  logic       parity_reg, parity_next;
  logic       tx_reg,     tx_next;
  logic       busy_reg,   busy_next;
  logic       done_reg,   done_next;

  logic       bit_end;

  assign bit_end = (baud_reg == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      baud_reg    <= 8'd0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'd0;
      parity_reg  <= 1'b0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    baud_next    = bit_end ? 8'd0 : baud_reg + 8'd1;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    tx_next      = tx_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next      = 1'b1;
        busy_next    = 1'b0;
        baud_next    = 8'd0;
        bit_idx_next = 3'd0;
        if (tx_en) begin
          // Parity is fixed at accept time so later datain changes cannot leak in.
          shift_next  = datain;
          parity_next = (^datain) ^ PAR_ODD;
          tx_next     = 1'b0;
          busy_next   = 1'b1;
          state_next  = START;
        end
      end

      START: begin
        if (bit_end) begin
          tx_next      = shift_reg[0];
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == 3'd7) begin
            if (PAR_EN) begin
              tx_next    = parity_reg;
              state_next = PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = STOP;
            end
          end else begin
            tx_next      = shift_reg[0];
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          tx_next    = 1'b1;
          state_next = STOP;
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        baud_next  = 8'd0;
      end
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = busy_reg;
  assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three parameterisations share stimulus; a receiver-style
// monitor decodes the selected instance's line and checks it against a scoreboard.
module tb_uart_tx_frame;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_en = 1'b0;
  logic [7:0] datain = 8'h00;
  logic       tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
  logic       tx_s, busy_s, done_s;
  int         sel = 0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .datain(datain), .tx_en(tx_en),
    .tx(tx0), .tx_busy(busy0), .tx_done(done0));
  uart_tx_frame #(.CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .datain(datain), .tx_en(tx_en),
    .tx(tx1), .tx_busy(busy1), .tx_done(done1));
  uart_tx_frame #(.CLKS_PER_BIT(N), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
    .clk(clk), .rst_n(rst_n), .datain(datain), .tx_en(tx_en),
    .tx(tx2), .tx_busy(busy2), .tx_done(done2));

  assign tx_s   = (sel == 0) ? tx0   : (sel == 1) ? tx1   : tx2;
  assign busy_s = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  assign done_s = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;

  typedef struct {
    logic [7:0]  data;
    int          nbits;
    logic        par_en;
    logic        odd;
    logic [10:0] bits;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [7:0] d, input int s);
    exp_t e;
    e.data   = d;
    e.par_en = (s != 2);
    e.odd    = (s == 1);
    e.bits   = '1;
    e.bits[0] = 1'b0;
    e.bits[8:1] = d;
    if (e.par_en) begin
      e.bits[9] = (^d) ^ e.odd;
      e.nbits   = 11;
    end else begin
      e.bits[9] = 1'b1;
      e.nbits   = 10;
    end
    return e;
  endfunction

  // Monitor / receiver model
  logic        mon_active = 1'b0;
  int          mon_cnt = 0, mon_bad = 0, mon_dones = 0;
  int          frames_seen = 0, gap_cnt = 0, last_gap = 0;
  logic [10:0] rx_bits;
  exp_t        cur;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
        gap_cnt    = 0;
      end else begin
        if (!mon_active && busy_s) begin
          mon_active = 1'b1;
          mon_cnt    = 1;
          mon_bad    = 0;
          mon_dones  = 0;
          rx_bits    = '1;
          last_gap   = gap_cnt;
          chk("frame_expected", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) cur = sb_q.pop_front();
          else cur = make_exp(8'h00, sel);
        end else if (!mon_active) begin
          gap_cnt++;
          if (tx_s !== 1'b1) mon_bad++;
        end
        if (mon_active) begin
          if (busy_s) begin
            int k;
            k = (mon_cnt - 1) / N;
            if (k >= cur.nbits) mon_bad++;
            else if (tx_s !== cur.bits[k]) mon_bad++;
            if (k < 11 && mon_cnt == k * N + N / 2) rx_bits[k] = tx_s;
            if (done_s) mon_dones++;
            mon_cnt++;
          end else begin
            logic [7:0] rx_byte;
            logic       err_check, err_frame;
            rx_byte   = rx_bits[8:1];
            err_check = cur.par_en && (rx_bits[9] !== ((^rx_byte) ^ cur.odd));
            err_frame = (rx_bits[cur.nbits-1] !== 1'b1);
            frames_seen++;
            $display("frame %0d: inst=%0d sent=%02h rx=%02h len=%0d rx_ok=%0d",
                     frames_seen, sel, cur.data, rx_byte, mon_cnt - 1,
                     !(err_check || err_frame));
            chk("frame_len", 32'(mon_cnt - 1), 32'(cur.nbits * N));
            chk("tx_waveform_bad_cycles", 32'(mon_bad), 32'd0);
            chk("rx_dataout", 32'(rx_byte), 32'(cur.data));
            if (cur.par_en) chk("rx_parity_bit", 32'(rx_bits[9]), 32'(cur.bits[9]));
            chk("err_check", 32'(err_check), 32'd0);
            chk("err_frame", 32'(err_frame), 32'd0);
            chk("tx_done_at_busy_fall", 32'(done_s), 32'd1);
            chk("tx_done_early", 32'(mon_dones), 32'd0);
            chk("tx_after_frame", 32'(tx_s), 32'd1);
            mon_active = 1'b0;
            mon_bad    = 0;
            gap_cnt    = 1;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    datain = d;
    tx_en  = 1'b1;
    sb_q.push_back(make_exp(d, sel));
    @(negedge clk);
    tx_en  = 1'b0;
    datain = ~d;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy0 || busy1 || busy2 || mon_active) && n < budget);
    chk("wait_idle_in_budget", 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, n;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("reset_tx", 32'(tx0), 32'd1);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_done", 32'(done0), 32'd0);

    // tx_en during reset: no frame may start
    @(negedge clk);
    tx_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_wins_busy", 32'(busy0), 32'd0);
    chk("reset_wins_tx", 32'(tx0), 32'd1);
    tx_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle 50 cycles
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_line", {29'd0, tx0, busy0, done0}, {29'd0, 1'b1, 1'b0, 1'b0});
    end

    // Basic frame, plus an ignored mid-frame request
    f0 = frames_seen;
    send(8'h55);
    repeat (78) @(negedge clk);
    datain = 8'hEE;
    tx_en  = 1'b1;
    @(negedge clk);
    tx_en  = 1'b0;
    wait_idle(400);
    repeat (20) @(negedge clk);
    chk("midframe_req_ignored", 32'(frames_seen - f0), 32'd1);

    // Parity variants for 0x07
    send(8'h07);
    wait_idle(400);
    sel = 1;
    send(8'h07);
    wait_idle(400);
    sel = 2;
    send(8'h07);
    wait_idle(400);
    sel = 0;

    // Held tx_en streams two frames with a 1-cycle gap
    f0 = frames_seen;
    @(negedge clk);
    datain = 8'hA3;
    tx_en  = 1'b1;
    sb_q.push_back(make_exp(8'hA3, sel));
    @(negedge clk);
    datain = 8'h3C;
    sb_q.push_back(make_exp(8'h3C, sel));
    n = 0;
    while (!(mon_active && frames_seen == f0 + 1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    tx_en = 1'b0;
    chk("stream_second_accept", 32'(n < 400), 32'd1);
    chk("stream_gap_cycles", 32'(last_gap), 32'd1);
    wait_idle(400);
    chk("stream_frame_count", 32'(frames_seen - f0), 32'd2);

    // Async reset at cycle 60 of a frame
    f0 = frames_seen;
    send(8'hC6);
    repeat (58) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_tx", 32'(tx0), 32'd1);
    chk("async_reset_busy", 32'(busy0), 32'd0);
    chk("async_reset_done", 32'(done0), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_done", 32'(done0), 32'd0);
    end
    rst_n = 1'b1;
    chk("aborted_frame_not_counted", 32'(frames_seen - f0), 32'd0);
    sb_q.delete();
    send(8'h81);
    wait_idle(400);
    chk("post_reset_frame", 32'(frames_seen - f0), 32'd1);

    // Loopback bytes
    send(8'h00);
    wait_idle(400);
    send(8'hFF);
    wait_idle(400);
    send(8'h5A);
    wait_idle(400);
    send(8'hA5);
    wait_idle(400);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
